// File: rtl/pkg_escrita.sv
// Shared widths, entry layout and sizing helper for the register-file write-back queue.
package pkg_escrita;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // One pending register-file write
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Ceiling log2, used for pointer and occupancy widths
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/busca_bypass.sv
// Youngest-match search across queued writes and the register-file output stage.
// Only instantiated when WB_BYPASS_EN is defined.
module busca_bypass
  import pkg_escrita::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  entry_t            entradas_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              saida_valida_i,
  input  entry_t            saida_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx_c;

  // Scan oldest to youngest so later (younger) matches overwrite earlier ones
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx_c  = head_i;
    if (addr_i != '0) begin
      if (saida_valida_i && (saida_i.rd == addr_i)) begin
        hit_o  = 1'b1;
        data_o = saida_i.data;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx_c = head_i + PTR_W'(k);
        if ((CNT_W'(k) < count_i) && (entradas_i[idx_c].rd == addr_i)) begin
          hit_o  = 1'b1;
          data_o = entradas_i[idx_c].data;
        end
      end
    end
  end

endmodule

// File: rtl/fila_escrita_registradores.sv
// In-order write-back queue feeding the register-file write port.
// Accepts load and ALU results (load is older), drains one write per cycle.
// Optional feature macro: WB_BYPASS_EN enables the two pending-write lookup ports.
module fila_escrita_registradores #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = pkg_escrita::DATA_W,
  parameter int unsigned ADDR_W = pkg_escrita::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              wb_stall,
  output logic              regWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] dadosEscrita,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              vazio,
  output logic              erro
);

  import pkg_escrita::*;

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t            fila_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] dados_q, dados_d;
  logic              erro_q, erro_d;

  logic [CNT_W-1:0]  space_c;
  logic              push_ld_c, push_alu_c, pop_c;
  logic [PTR_W-1:0]  alu_ptr_c;
  entry_t            ld_entry_c, alu_entry_c;

  // Free slots come from the registered count only; a same-cycle pop gives no credit
  always_comb begin
    space_c   = CNT_W'(DEPTH) - count_q;
    ld_ready  = (space_c >= CNT_W'(1));
    alu_ready = ld_valid ? (space_c >= CNT_W'(2)) : (space_c >= CNT_W'(1));
  end

  // Handshake, push/pop decisions and next-state values
  always_comb begin
    push_ld_c   = ld_valid && ld_ready && (ld_rd != '0);
    push_alu_c  = alu_valid && alu_ready && (alu_rd != '0);
    pop_c       = (count_q != '0) && !wb_stall;
    alu_ptr_c   = tail_q + PTR_W'(push_ld_c);
    ld_entry_c  = '{rd: ld_rd, data: ld_data};
    alu_entry_c = '{rd: alu_rd, data: alu_data};

    tail_d  = tail_q + PTR_W'(push_ld_c) + PTR_W'(push_alu_c);
    head_d  = head_q + PTR_W'(pop_c);
    count_d = count_q + CNT_W'(push_ld_c) + CNT_W'(push_alu_c) - CNT_W'(pop_c);

    regwrite_d = pop_c;
    rd_d       = rd_q;
    dados_d    = dados_q;
    if (pop_c) begin
      rd_d    = fila_q[head_q].rd;
      dados_d = fila_q[head_q].data;
    end

    erro_d = erro_q || (ld_valid && !ld_ready) || (alu_valid && !alu_ready);
  end

  // Entry storage; stale slots are harmless because occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (push_ld_c)  fila_q[tail_q]    <= ld_entry_c;
    if (push_alu_c) fila_q[alu_ptr_c] <= alu_entry_c;
  end

  // Pointers, occupancy, output stage and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      dados_q    <= '0;
      erro_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      dados_q    <= dados_d;
      erro_q     <= erro_d;
    end
  end

  assign regWrite     = regwrite_q;
  assign RD           = rd_q;
  assign dadosEscrita = dados_q;
  assign erro         = erro_q;
  assign vazio        = (count_q == '0) && !regwrite_q;

`ifdef WB_BYPASS_EN
  entry_t saida_c;
  assign saida_c = '{rd: rd_q, data: dados_q};

  busca_bypass #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_busca1 (
    .entradas_i     (fila_q),
    .head_i         (head_q),
    .count_i        (count_q),
    .saida_valida_i (regwrite_q),
    .saida_i        (saida_c),
    .addr_i         (q1_addr),
    .hit_o          (q1_hit),
    .data_o         (q1_data)
  );

  busca_bypass #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_busca2 (
    .entradas_i     (fila_q),
    .head_i         (head_q),
    .count_i        (count_q),
    .saida_valida_i (regwrite_q),
    .saida_i        (saida_c),
    .addr_i         (q2_addr),
    .hit_o          (q2_hit),
    .data_o         (q2_data)
  );
`else
  // Lookup disabled: addresses are intentionally ignored
  logic unused_q_addr;
  assign unused_q_addr = ^{q1_addr, q2_addr};
  assign q1_hit  = 1'b0;
  assign q2_hit  = 1'b0;
  assign q1_data = '0;
  assign q2_data = '0;
`endif

endmodule

// File: tb/tb_fila_escrita_registradores.sv
// Directed bench for the write-back queue: vector table plus bypass sequence.
module tb_fila_escrita_registradores;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid, alu_valid, wb_stall;
  logic [4:0]  ld_rd, alu_rd, q1_addr, q2_addr;
  logic [31:0] ld_data, alu_data;
  logic        ld_ready, alu_ready, regWrite, q1_hit, q2_hit, vazio, erro;
  logic [4:0]  RD;
  logic [31:0] dadosEscrita, q1_data, q2_data;

  int total = 0;
  int bad   = 0;

  fila_escrita_registradores dut (
    .clock        (clock),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .wb_stall     (wb_stall),
    .regWrite     (regWrite),
    .RD           (RD),
    .dadosEscrita (dadosEscrita),
    .q1_addr      (q1_addr),
    .q2_addr      (q2_addr),
    .q1_hit       (q1_hit),
    .q2_hit       (q2_hit),
    .q1_data      (q1_data),
    .q2_data      (q2_data),
    .vazio        (vazio),
    .erro         (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        stl;
    logic        e_ldr;
    logic        e_alr;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    logic        e_vz;
    logic        e_er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%08h want=0x%08h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic av, input logic [4:0] ard, input logic [31:0] adat, input logic stl,
                     input logic e_ldr, input logic e_alr, input logic e_rw, input logic [4:0] e_rd,
                     input logic [31:0] e_dat, input logic e_vz, input logic e_er);
    vec_t v;
    v.rst = rst; v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.av = av; v.ard = ard; v.adat = adat;
    v.stl = stl; v.e_ldr = e_ldr; v.e_alr = e_alr; v.e_rw = e_rw; v.e_rd = e_rd; v.e_dat = e_dat;
    v.e_vz = e_vz; v.e_er = e_er;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    reset = 1'b0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; wb_stall = 1'b0;
  endtask

  task automatic push_ld_one(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clock);
    drive_idle();
    wb_stall = 1'b1; ld_valid = 1'b1; ld_rd = rd; ld_data = d;
    @(posedge clock); #1;
  endtask

  task automatic check_bypass(input string name, input logic [4:0] a1, input logic e1_hit,
                              input logic [31:0] e1_dat, input logic [4:0] a2);
    logic        exp_hit;
    logic [31:0] exp_dat;
`ifdef WB_BYPASS_EN
    exp_hit = e1_hit; exp_dat = e1_dat;
`else
    exp_hit = 1'b0;   exp_dat = 32'h0;
`endif
    q1_addr = a1; q2_addr = a2;
    #1;
    chk({name, "_q1_hit"}, 0, 32'(q1_hit), 32'(exp_hit));
    chk({name, "_q1_data"}, 0, q1_data, exp_dat);
    chk({name, "_q2_hit"}, 0, 32'(q2_hit), 32'h0);
    chk({name, "_q2_data"}, 0, q2_data, 32'h0);
  endtask

  initial begin
    drive_idle();
    q1_addr = '0; q2_addr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_regWrite", -1, 32'(regWrite), 32'h0);
    chk("rst_RD", -1, 32'(RD), 32'h0);
    chk("rst_dados", -1, dadosEscrita, 32'h0);
    chk("rst_vazio", -1, 32'(vazio), 32'h1);
    chk("rst_erro", -1, 32'(erro), 32'h0);
    chk("rst_ld_ready", -1, 32'(ld_ready), 32'h1);

    //   rst lv lrd ldat          av ard adat   stl | ldr alr rw rd  dat           vz er
    // single load, latency and empty flag
    add(0, 1, 5'd3, 32'hAAAA5555, 0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd0, 32'h0,        0, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd3, 32'hAAAA5555, 0, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd3, 32'hAAAA5555, 1, 0);
    // load + ALU in one cycle: load drains first
    add(0, 1, 5'd4, 32'h1,        1, 5'd5, 32'h2,  0,   1, 1, 0, 5'd3, 32'hAAAA5555, 0, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd4, 32'h1,        0, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd5, 32'h2,        0, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd5, 32'h2,        1, 0);
    // fill under stall, overflow attempt, then ordered drain
    add(0, 1, 5'd6, 32'h60,       1, 5'd7, 32'h70, 1,   1, 1, 0, 5'd5, 32'h2,        0, 0);
    add(0, 1, 5'd8, 32'h80,       1, 5'd9, 32'h90, 1,   1, 1, 0, 5'd5, 32'h2,        0, 0);
    add(0, 1, 5'd10, 32'hA0,      0, 5'd0, 32'h0,  1,   0, 0, 0, 5'd5, 32'h2,        0, 1);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   0, 0, 1, 5'd6, 32'h60,       0, 1);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd7, 32'h70,       0, 1);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd8, 32'h80,       0, 1);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 1, 5'd9, 32'h90,       0, 1);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd9, 32'h90,       1, 1);
    // reset clears sticky error and output stage
    add(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd0, 32'h0,        1, 0);
    // destination 0 is accepted but never written
    add(0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h7,  0,   1, 1, 0, 5'd0, 32'h0,        1, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd0, 32'h0,        1, 0);
    // one free slot: load wins, ALU refused
    add(0, 1, 5'd11, 32'hB1,      1, 5'd12, 32'hB2, 1,  1, 1, 0, 5'd0, 32'h0,        0, 0);
    add(0, 1, 5'd13, 32'hB3,      0, 5'd0, 32'h0,  1,   1, 1, 0, 5'd0, 32'h0,        0, 0);
    add(0, 1, 5'd15, 32'hB5,      1, 5'd16, 32'hB6, 1,  1, 0, 0, 5'd0, 32'h0,        0, 1);
    // reset with a full queue discards everything
    add(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   0, 0, 0, 5'd0, 32'h0,        1, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd0, 32'h0,        1, 0);
    add(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0,   1, 1, 0, 5'd0, 32'h0,        1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst; ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_data = vecs[i].ldat;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat; wb_stall = vecs[i].stl;
      #1;
      chk("ld_ready", i, 32'(ld_ready), 32'(vecs[i].e_ldr));
      chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_alr));
      @(posedge clock); #1;
      chk("regWrite", i, 32'(regWrite), 32'(vecs[i].e_rw));
      chk("RD", i, 32'(RD), 32'(vecs[i].e_rd));
      chk("dadosEscrita", i, dadosEscrita, vecs[i].e_dat);
      chk("vazio", i, 32'(vazio), 32'(vecs[i].e_vz));
      chk("erro", i, 32'(erro), 32'(vecs[i].e_er));
    end

    // Bypass: youngest pending value wins, then output stage
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    @(posedge clock); #1;
    push_ld_one(5'd9, 32'h10);
    push_ld_one(5'd9, 32'h20);
    push_ld_one(5'd4, 32'h44);
    @(negedge clock);
    drive_idle();
    wb_stall = 1'b1;
    check_bypass("byp_young", 5'd9, 1'b1, 32'h20, 5'd0);
    check_bypass("byp_miss", 5'd3, 1'b0, 32'h0, 5'd0);
    check_bypass("byp_other", 5'd4, 1'b1, 32'h44, 5'd0);
    // drain: rd9/0x10 to output stage, rd9/0x20 still queued
    wb_stall = 1'b0;
    @(posedge clock); #1;
    chk("byp_drain1_RD", 0, 32'(RD), 32'd9);
    chk("byp_drain1_dados", 0, dadosEscrita, 32'h10);
    @(negedge clock);
    wb_stall = 1'b1;
    check_bypass("byp_q_over_out", 5'd9, 1'b1, 32'h20, 5'd0);
    wb_stall = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    // rd9/0x20 popped, rd4 in output stage now; then queue empty
    chk("byp_drain3_RD", 0, 32'(RD), 32'd4);
    @(negedge clock);
    check_bypass("byp_out_stage", 5'd4, 1'b1, 32'h44, 5'd0);
    check_bypass("byp_gone", 5'd9, 1'b0, 32'h0, 5'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_bypass("byp_idle", 5'd4, 1'b0, 32'h0, 5'd0);
    chk("byp_vazio", 0, 32'(vazio), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
